// File: rtl/scan_ctrl8.sv
// scan_ctrl8: time-multiplexed scan controller for an 8-digit common-select display.
// Drives the 3-to-8 decoder select, blanks between digits and double-buffers the
// display data so a host write only becomes visible at a frame boundary.
//
// state    | meaning
// ST_IDLE  | not scanning, all digits dark
// ST_BLANK | inter-digit gap, all digits dark, o_sel already on the next digit
// ST_SHOW  | digit o_sel lit with active-buffer nibble
module scan_ctrl8 #(
   parameter int DWELL = 1000,
   parameter int BLANK = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic [7:0]  i_digit_mask,
   input  logic        i_wr_vld,
   input  logic [31:0] i_wr_data,
   output logic        o_wr_rdy,
   output logic [2:0]  o_sel,
   output logic        o_blank,
   output logic [3:0]  o_digit,
   output logic        o_frame_done
);

   localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   // Load values are one less than the phase length: the phase ends on terminal count 0.
   localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [2:0]     sel_q, sel_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           blank_q;
   logic           frame_done_q, frame_done_d;
   logic [31:0]    active_q, shadow_q;
   logic           pending_q;
   logic           xfer;
   logic [2:0]     low_idx;
   logic [2:0]     nxt_idx;
   logic           nxt_wrap;

   // Lowest enabled digit, and the next enabled digit above o_sel (wrapping to the lowest).
   always_comb begin
      low_idx  = 3'd0;
      nxt_idx  = 3'd0;
      nxt_wrap = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         if (i_digit_mask[i]) begin
            low_idx = 3'(i);
         end
      end
      nxt_idx = low_idx;
      for (int i = 7; i >= 0; i--) begin
         if (i_digit_mask[i] && (3'(i) > sel_q)) begin
            nxt_idx  = 3'(i);
            nxt_wrap = 1'b0;
         end
      end
   end

   // Next-state, select and phase counter; frame end raises frame_done and the buffer swap.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      xfer         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_en && (i_digit_mask != 8'd0)) begin
               sel_d = low_idx;
               if (BLANK == 0) begin
                  state_d = ST_SHOW;
                  cnt_d   = DWELL_LD;
               end else begin
                  state_d = ST_BLANK;
                  cnt_d   = BLANK_LD;
               end
            end
         end
         ST_BLANK: begin
            if (!i_en) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_SHOW;
               cnt_d   = DWELL_LD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_SHOW: begin
            if (!i_en) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               if (i_digit_mask == 8'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  sel_d        = nxt_idx;
                  frame_done_d = nxt_wrap;
                  xfer         = nxt_wrap & pending_q;
                  if (BLANK == 0) begin
                     state_d = ST_SHOW;
                     cnt_d   = DWELL_LD;
                  end else begin
                     state_d = ST_BLANK;
                     cnt_d   = BLANK_LD;
                  end
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Scan state registers; blank is registered from the next state so it lines up with o_sel.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         sel_q        <= 3'd0;
         cnt_q        <= '0;
         blank_q      <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         blank_q      <= (state_d != ST_SHOW);
         frame_done_q <= frame_done_d;
      end
   end

   // Double buffer: host fills shadow while free; shadow moves to active only at frame end.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         active_q  <= 32'd0;
         shadow_q  <= 32'd0;
         pending_q <= 1'b0;
      end else if (xfer) begin
         active_q  <= shadow_q;
         pending_q <= 1'b0;
      end else if (i_wr_vld && !pending_q) begin
         shadow_q  <= i_wr_data;
         pending_q <= 1'b1;
      end
   end

   assign o_wr_rdy     = ~pending_q;
   assign o_sel        = sel_q;
   assign o_blank      = blank_q;
   assign o_frame_done = frame_done_q;
   assign o_digit      = active_q[{sel_q, 2'b00} +: 4];

endmodule

// File: tb/tb_scan_ctrl8.sv
// Directed bench for scan_ctrl8: a DWELL=4/BLANK=2 instance for scan, buffering and
// reset behaviour, and a BLANK=0/DWELL=1 instance for the back-to-back single-digit case.
module tb_scan_ctrl8;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, wr_vld;
   logic [7:0]  mask;
   logic [31:0] wr_data;
   logic        wr_rdy, blank, fd;
   logic [2:0]  sel;
   logic [3:0]  digit;

   logic        rst_1, en_1, wr_vld_1;
   logic [7:0]  mask_1;
   logic [31:0] wr_data_1;
   logic        wr_rdy_1, blank_1, fd_1;
   logic [2:0]  sel_1;
   logic [3:0]  digit_1;

   int checks   = 0;
   int failures = 0;
   int k        = 0;

   logic [2:0] exp_sel;
   logic       exp_blank;
   logic       exp_fd;

   scan_ctrl8 #(.DWELL(4), .BLANK(2)) u0 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_digit_mask(mask),
      .i_wr_vld(wr_vld), .i_wr_data(wr_data), .o_wr_rdy(wr_rdy),
      .o_sel(sel), .o_blank(blank), .o_digit(digit), .o_frame_done(fd)
   );

   scan_ctrl8 #(.DWELL(1), .BLANK(0)) u1 (
      .i_clk(clk), .i_rst(rst_1), .i_en(en_1), .i_digit_mask(mask_1),
      .i_wr_vld(wr_vld_1), .i_wr_data(wr_data_1), .o_wr_rdy(wr_rdy_1),
      .o_sel(sel_1), .o_blank(blank_1), .o_digit(digit_1), .o_frame_done(fd_1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; mask = 8'h00; wr_vld = 1'b0; wr_data = 32'h0;
      rst_1 = 1'b1; en_1 = 1'b0; mask_1 = 8'h00; wr_vld_1 = 1'b0; wr_data_1 = 32'h0;
      step();
      step();
      checks++; if (sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
      checks++; if (blank !== 1'b1) begin failures++; $display("FAIL reset_blank got=%b exp=1", blank); end
      checks++; if (digit !== 4'd0) begin failures++; $display("FAIL reset_digit got=%h exp=0", digit); end
      checks++; if (wr_rdy !== 1'b1) begin failures++; $display("FAIL reset_wr_rdy got=%b exp=1", wr_rdy); end
      checks++; if (fd !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", fd); end
      checks++; if (blank_1 !== 1'b1) begin failures++; $display("FAIL reset1_blank got=%b exp=1", blank_1); end
      checks++; if (wr_rdy_1 !== 1'b1) begin failures++; $display("FAIL reset1_wr_rdy got=%b exp=1", wr_rdy_1); end
      checks++; if (fd_1 !== 1'b0) begin failures++; $display("FAIL reset1_frame_done got=%b exp=0", fd_1); end
   endtask

   // k counts edges since scan start; 6-cycle digit period: 2 blank then 4 lit.
   task automatic test_scan();
      mask = 8'hFF; en = 1'b1; rst = 1'b0; k = 0;
      for (int c = 0; c < 100; c++) begin
         step(); k++;
         exp_sel   = 3'(((k - 1) / 6) % 8);
         exp_blank = (((k - 1) % 6) < 2);
         exp_fd    = (k > 1) && (((k - 1) % 48) == 0);
         checks++; if (sel !== exp_sel) begin failures++; $display("FAIL scan_sel k=%0d got=%0d exp=%0d", k, sel, exp_sel); end
         checks++; if (blank !== exp_blank) begin failures++; $display("FAIL scan_blank k=%0d got=%b exp=%b", k, blank, exp_blank); end
         checks++; if (fd !== exp_fd) begin failures++; $display("FAIL scan_frame_done k=%0d got=%b exp=%b", k, fd, exp_fd); end
         checks++; if (digit !== 4'd0) begin failures++; $display("FAIL scan_digit k=%0d got=%h exp=0", k, digit); end
      end
   endtask

   task automatic test_write();
      wr_data = 32'h76543210; wr_vld = 1'b1;
      step(); k++;
      wr_vld = 1'b0;
      checks++; if (wr_rdy !== 1'b0) begin failures++; $display("FAIL write_rdy_drop got=%b exp=0", wr_rdy); end
      checks++; if (digit !== 4'd0) begin failures++; $display("FAIL write_digit_hold got=%h exp=0", digit); end
   endtask

   task automatic test_second_write();
      logic found;
      wr_data = 32'hFFFFFFFF; wr_vld = 1'b1;
      step(); k++;
      wr_vld = 1'b0;
      checks++; if (wr_rdy !== 1'b0) begin failures++; $display("FAIL second_write_rdy got=%b exp=0", wr_rdy); end
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         step(); k++;
         if (fd === 1'b1) begin
            found = 1'b1;
         end else begin
            checks++; if (digit !== 4'd0) begin failures++; $display("FAIL pre_boundary_digit k=%0d got=%h exp=0", k, digit); end
            checks++; if (wr_rdy !== 1'b0) begin failures++; $display("FAIL pre_boundary_rdy k=%0d got=%b exp=0", k, wr_rdy); end
         end
      end
      checks++; if (!found) begin failures++; $display("FAIL boundary_timeout got=none exp=frame_done within 60 cycles"); end
      checks++; if (k !== 145) begin failures++; $display("FAIL boundary_time got=%0d exp=145", k); end
      checks++; if (sel !== 3'd0) begin failures++; $display("FAIL boundary_sel got=%0d exp=0", sel); end
      checks++; if (wr_rdy !== 1'b1) begin failures++; $display("FAIL boundary_rdy got=%b exp=1", wr_rdy); end
      for (int c = 0; c < 47; c++) begin
         step(); k++;
         exp_sel = 3'(((k - 1) / 6) % 8);
         checks++; if (sel !== exp_sel) begin failures++; $display("FAIL post_sel k=%0d got=%0d exp=%0d", k, sel, exp_sel); end
         checks++; if (digit !== {1'b0, exp_sel}) begin failures++; $display("FAIL post_digit k=%0d got=%h exp=%h", k, digit, exp_sel); end
      end
   endtask

   task automatic test_reset_mid();
      wr_data = 32'hAAAAAAAA; wr_vld = 1'b1;
      step(); k++;
      wr_vld = 1'b0;
      while (k < 214) begin
         step(); k++;
      end
      checks++; if (sel !== 3'd3) begin failures++; $display("FAIL mid_sel got=%0d exp=3", sel); end
      checks++; if (blank !== 1'b0) begin failures++; $display("FAIL mid_blank got=%b exp=0", blank); end
      checks++; if (digit !== 4'd3) begin failures++; $display("FAIL mid_digit got=%h exp=3", digit); end
      checks++; if (wr_rdy !== 1'b0) begin failures++; $display("FAIL mid_pending got=%b exp=0", wr_rdy); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (sel !== 3'd0) begin failures++; $display("FAIL rst_mid_sel got=%0d exp=0", sel); end
      checks++; if (blank !== 1'b1) begin failures++; $display("FAIL rst_mid_blank got=%b exp=1", blank); end
      checks++; if (digit !== 4'd0) begin failures++; $display("FAIL rst_mid_digit got=%h exp=0", digit); end
      checks++; if (wr_rdy !== 1'b1) begin failures++; $display("FAIL rst_mid_rdy got=%b exp=1", wr_rdy); end
      checks++; if (fd !== 1'b0) begin failures++; $display("FAIL rst_mid_frame_done got=%b exp=0", fd); end
      k = 0;
      for (int c = 0; c < 60; c++) begin
         step(); k++;
         exp_sel   = 3'(((k - 1) / 6) % 8);
         exp_blank = (((k - 1) % 6) < 2);
         exp_fd    = (k > 1) && (((k - 1) % 48) == 0);
         checks++; if (sel !== exp_sel) begin failures++; $display("FAIL restart_sel k=%0d got=%0d exp=%0d", k, sel, exp_sel); end
         checks++; if (blank !== exp_blank) begin failures++; $display("FAIL restart_blank k=%0d got=%b exp=%b", k, blank, exp_blank); end
         checks++; if (fd !== exp_fd) begin failures++; $display("FAIL restart_frame_done k=%0d got=%b exp=%b", k, fd, exp_fd); end
         checks++; if (digit !== 4'd0) begin failures++; $display("FAIL restart_digit k=%0d got=%h exp=0", k, digit); end
         checks++; if (wr_rdy !== 1'b1) begin failures++; $display("FAIL restart_rdy k=%0d got=%b exp=1", k, wr_rdy); end
      end
   endtask

   task automatic test_mask24();
      rst = 1'b1;
      step();
      rst = 1'b0; mask = 8'h24; en = 1'b1; k = 0;
      for (int c = 0; c < 42; c++) begin
         step(); k++;
         exp_sel   = ((((k - 1) / 6) % 2) == 0) ? 3'd2 : 3'd5;
         exp_blank = (((k - 1) % 6) < 2);
         exp_fd    = (k > 1) && (((k - 1) % 12) == 0);
         checks++; if (sel !== exp_sel) begin failures++; $display("FAIL m24_sel k=%0d got=%0d exp=%0d", k, sel, exp_sel); end
         checks++; if (blank !== exp_blank) begin failures++; $display("FAIL m24_blank k=%0d got=%b exp=%b", k, blank, exp_blank); end
         checks++; if (fd !== exp_fd) begin failures++; $display("FAIL m24_frame_done k=%0d got=%b exp=%b", k, fd, exp_fd); end
         if (k == 40) mask = 8'h00;
      end
      for (int c = 0; c < 4; c++) begin
         step(); k++;
         checks++; if (blank !== 1'b1) begin failures++; $display("FAIL m0_blank k=%0d got=%b exp=1", k, blank); end
         checks++; if (sel !== 3'd2) begin failures++; $display("FAIL m0_sel_hold k=%0d got=%0d exp=2", k, sel); end
         checks++; if (fd !== 1'b0) begin failures++; $display("FAIL m0_frame_done k=%0d got=%b exp=0", k, fd); end
      end
   endtask

   task automatic test_back_to_back();
      rst_1 = 1'b0; en_1 = 1'b1; mask_1 = 8'h01;
      wr_data_1 = 32'h0000000C; wr_vld_1 = 1'b1;
      step();
      wr_vld_1 = 1'b0;
      checks++; if (blank_1 !== 1'b0) begin failures++; $display("FAIL b2b_start_blank got=%b exp=0", blank_1); end
      checks++; if (fd_1 !== 1'b0) begin failures++; $display("FAIL b2b_start_frame_done got=%b exp=0", fd_1); end
      checks++; if (digit_1 !== 4'd0) begin failures++; $display("FAIL b2b_start_digit got=%h exp=0", digit_1); end
      checks++; if (wr_rdy_1 !== 1'b0) begin failures++; $display("FAIL b2b_start_rdy got=%b exp=0", wr_rdy_1); end
      for (int c = 0; c < 10; c++) begin
         step();
         checks++; if (blank_1 !== 1'b0) begin failures++; $display("FAIL b2b_blank c=%0d got=%b exp=0", c, blank_1); end
         checks++; if (fd_1 !== 1'b1) begin failures++; $display("FAIL b2b_frame_done c=%0d got=%b exp=1", c, fd_1); end
         checks++; if (digit_1 !== 4'hC) begin failures++; $display("FAIL b2b_digit c=%0d got=%h exp=c", c, digit_1); end
         checks++; if (wr_rdy_1 !== 1'b1) begin failures++; $display("FAIL b2b_rdy c=%0d got=%b exp=1", c, wr_rdy_1); end
         checks++; if (sel_1 !== 3'd0) begin failures++; $display("FAIL b2b_sel c=%0d got=%0d exp=0", c, sel_1); end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_write();
      test_second_write();
      test_reset_mid();
      test_mask24();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scan_ctrl8.md
Name: scan_ctrl8

Overview:
- Time-multiplexed scan controller for an 8-digit common-select display.
- Drives the 3-bit select of the team's 3-to-8 decoder and presents the nibble for the selected digit.
- Inserts a blanking gap between digits to prevent ghosting.
- Holds display data in a double buffer so host writes never tear a frame.

Parameters:
- DWELL, 1000, clock cycles each digit is lit (>=1).
- BLANK, 16, clock cycles all digits dark before each digit is lit (0 = no gap).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset; synchronous, active-high
- i_en  input  1  scan enable
- i_digit_mask  input  8  bit n=1 includes digit n in the scan
- i_wr_vld  input  1  host write request
- i_wr_data  input  32  8 nibbles; bits [4n+3:4n] hold digit n
- o_wr_rdy  output  1  shadow buffer free; write accepted when i_wr_vld & o_wr_rdy
- o_sel  output  3  digit index to decoder i_sel
- o_blank  output  1  1 = all digits dark (decoder output must be forced inactive)
- o_digit  output  4  active-buffer nibble for o_sel
- o_frame_done  output  1  one-cycle pulse per completed frame

Behaviour:
- Reset (i_rst=1 at a clock edge) applies from any state, mid-digit included:
  - state IDLE; o_sel=0; o_blank=1; o_digit=0; o_wr_rdy=1; o_frame_done=0.
  - Active buffer=0, shadow buffer=0, pending flag=0, counter=0.
- All outputs are registered. o_digit always equals active[o_sel] in the same cycle.
- Write path:
  - Accept: i_wr_vld & o_wr_rdy → shadow=i_wr_data, pending=1, o_wr_rdy=0 from next cycle.
  - o_wr_rdy = ~pending.
  - i_wr_vld while o_wr_rdy=0 is ignored; there is no queueing.
- States IDLE, BLANK, SHOW:
  - IDLE: o_blank=1.
    - If i_en=1 and mask!=0: o_sel=lowest set mask bit, go BLANK (or SHOW if BLANK=0), counter loaded.
    - Otherwise stay in IDLE.
  - BLANK: o_blank=1 for exactly BLANK cycles, then SHOW.
  - SHOW: o_blank=0 for exactly DWELL cycles. On the last cycle, advance:
    - Next index = next set mask bit above o_sel, wrapping to the lowest set bit; mask is sampled at this edge.
    - If the advance wraps (next <= current, including single-digit mask), it is a frame end.
    - Frame end: o_frame_done=1 for one cycle. If pending=1, active=shadow and pending=0, so the new data shows from the next digit.
    - If the sampled mask=0: go IDLE with no frame_done and no transfer.
    - Otherwise go BLANK (or SHOW if BLANK=0).
- i_en=0 in BLANK/SHOW: next cycle IDLE, o_blank=1, o_sel holds. No frame_done and no transfer; pending is retained.
- Frame-end transfer and a new write in the same cycle: impossible, since o_wr_rdy=0 while pending. With pending=0 at frame end, a same-cycle write lands in shadow and transfers at the following frame end.
- Per-digit period = BLANK+DWELL cycles. Frame period = popcount(mask)*(BLANK+DWELL).
- Counter width is clog2(max(DWELL,BLANK)+1). The counter counts down and reloads at each phase change, with no wrap beyond the loaded value.

Test Plan:
- DWELL=4, BLANK=2, mask=FF, i_en=1 after reset:
  - o_sel steps 0..7, each digit 2 cycles o_blank=1 then 4 cycles o_blank=0.
  - o_frame_done pulses every 48 cycles.
  - Each pulse is coincident with o_sel 7→0.
- Write 0x76543210 while idle-scanning:
  - o_wr_rdy drops next cycle.
  - o_digit unchanged until the frame boundary.
  - Afterwards o_digit=n for o_sel=n, and o_wr_rdy returns to 1 the same cycle.
- Second write while pending:
  - Ignored; displayed data equals the first write after the boundary.
- mask=0x24:
  - o_sel alternates 2,5.
  - frame_done pulses on 5→2 every 12 cycles.
  - Changing mask to 0x00 mid-SHOW → IDLE after that digit's dwell, o_blank=1.
- i_rst pulse mid-SHOW with pending write:
  - Next cycle all reset values: o_wr_rdy=1, o_digit=0, o_blank=1.
  - Scan restarts from lowest mask bit.
- BLANK=0, DWELL=1, mask=0x01:
  - o_blank held 0 continuously after start.
  - o_frame_done high every cycle.
  - A pending write transfers on the first boundary.
